// File: rtl/lottery_pkg.sv
// Shared types and constants for the lottery ticket generator.
//   state_e      : draw sequencer states
//   LFSR_W       : width of the random source
//   TICKET_W     : width of one per-master ticket count
//   LFSR_TAP     : feedback taps for x^6+x^5+1 (bits 5 and 4)
//   DEFAULT_SEED : LFSR value used when no (or a zero) seed is given
package lottery_pkg;

    localparam int unsigned LFSR_W   = 6;
    localparam int unsigned TICKET_W = 4;

    localparam logic [LFSR_W-1:0] LFSR_TAP     = 6'b110000;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 6'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAW  = 2'd2,
        GRANT = 2'd3
    } state_e;

    // The all-zero state is a lock-up state for this LFSR; map it to the default seed.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/lottery_lfsr6.sv
// 6-bit Fibonacci LFSR (x^6+x^5+1), period 63, never zero.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (loads SEED)
//   step      : advance one position
//   load      : overwrite with load_val (zero replaced by the default seed); wins over step
//   load_val  : value to load
//   q         : current LFSR value
module lottery_lfsr6
    import lottery_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next-value selection: load, step, or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = fix_seed(load_val);
        end else if (step) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAP)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= fix_seed(SEED);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/lottery_ticket_gen.sv
// Lottery arbiter producer: masks ticket counts with live requests, builds the
// cumulative thresholds s0..s3 and draws random_no in 1..s3 by rejection sampling.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request one draw (honoured in IDLE only)
//   r0..r3, t0..t3  : request lines and ticket counts, sampled in LOAD
//   s0..s3          : cumulative thresholds (s3 = draw total)
//   random_no       : accepted draw
//   enable          : s0..s3/random_no valid for the comparator (HOLD_CYCLES cycles)
//   busy            : sequencer not in IDLE
//   done, no_req    : end-of-draw pulse; no_req marks a zero-ticket draw
// Optional: define LOTTERY_SEED_LOAD_EN to add seed_load/seed_val (reseed in IDLE).
module lottery_ticket_gen
    import lottery_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 6'h01,
    parameter int unsigned       HOLD_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef LOTTERY_SEED_LOAD_EN
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed_val,
`endif
    input  logic                r0,
    input  logic                r1,
    input  logic                r2,
    input  logic                r3,
    input  logic [TICKET_W-1:0] t0,
    input  logic [TICKET_W-1:0] t1,
    input  logic [TICKET_W-1:0] t2,
    input  logic [TICKET_W-1:0] t3,
    output logic [3:0]          s0,
    output logic [4:0]          s1,
    output logic [5:0]          s2,
    output logic [5:0]          s3,
    output logic [LFSR_W-1:0]   random_no,
    output logic                enable,
    output logic                busy,
    output logic                done,
    output logic                no_req
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_e state_q, state_d;
    logic [3:0]        s0_q, s0_d;
    logic [4:0]        s1_q, s1_d;
    logic [5:0]        s2_q, s2_d;
    logic [5:0]        s3_q, s3_d;
    logic [LFSR_W-1:0] rn_q, rn_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              no_req_q, no_req_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [TICKET_W-1:0] e0, e1, e2, e3;
    logic [4:0]          sum1;
    logic [5:0]          sum2, sum3;
    logic                lfsr_step, lfsr_load;
    logic [LFSR_W-1:0]   lfsr_load_val, lfsr_val;

    lottery_lfsr6 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .q        (lfsr_val)
    );

    // Masked tickets and running sums; widths are exact so no overflow.
    always_comb begin
        e0   = r0 ? t0 : '0;
        e1   = r1 ? t1 : '0;
        e2   = r2 ? t2 : '0;
        e3   = r3 ? t3 : '0;
        sum1 = 5'(e0) + 5'(e1);
        sum2 = 6'(sum1) + 6'(e2);
        sum3 = sum2 + 6'(e3);
    end

    // Reseed path: only acts in IDLE, and may coincide with start.
    always_comb begin
`ifdef LOTTERY_SEED_LOAD_EN
        lfsr_load     = seed_load && (state_q == IDLE);
        lfsr_load_val = seed_val;
`else
        lfsr_load     = 1'b0;
        lfsr_load_val = DEFAULT_SEED;
`endif
    end

    // Draw sequencer: next state and registered outputs.
    always_comb begin
        state_d   = state_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        s3_d      = s3_q;
        rn_d      = rn_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        no_req_d  = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                s0_d = e0;
                s1_d = sum1;
                s2_d = sum2;
                s3_d = sum3;
                if (sum3 == '0) begin
                    done_d   = 1'b1;
                    no_req_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                // LFSR never yields 0, so lfsr <= total gives a draw in 1..total.
                lfsr_step = 1'b1;
                if (lfsr_val <= s3_q) begin
                    rn_d    = lfsr_val;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (cnt_q == HOLD_LAST) begin
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s0_q     <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            rn_q     <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            no_req_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            rn_q     <= rn_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            no_req_q <= no_req_d;
            cnt_q    <= cnt_d;
        end
    end

    assign s0        = s0_q;
    assign s1        = s1_q;
    assign s2        = s2_q;
    assign s3        = s3_q;
    assign random_no = rn_q;
    assign enable    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign no_req    = no_req_q;

endmodule

// File: tb/tb_lottery_ticket_gen.sv
// Scoreboard bench for lottery_ticket_gen (default build, seed 1, one hold cycle).
module tb_lottery_ticket_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       r0, r1, r2, r3;
    logic [3:0] t0, t1, t2, t3;
    logic [3:0] s0;
    logic [4:0] s1;
    logic [5:0] s2, s3, random_no;
    logic       enable, busy, done, no_req;

    lottery_ticket_gen dut (
        .clk(clk), .rst(rst), .start(start),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .random_no(random_no), .enable(enable), .busy(busy),
        .done(done), .no_req(no_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s0, s1, s2, s3, rn;
        bit nr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_lfsr;
    int   m_ndraw;
    int   m_tot;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: Fibonacci x^6+x^5+1 as plain integer arithmetic.
    function automatic int lfsr_next(input int x);
        return ((x << 1) & 63) | (((x >> 5) ^ (x >> 4)) & 1);
    endfunction

    // Predict one draw from the rules: masked sums, then reject values above the total.
    task automatic predict(input int a, b, c, d, input logic [3:0] rm);
        exp_t e;
        int   e0, e1, e2, e3;
        e0 = rm[3] ? a : 0;
        e1 = rm[2] ? b : 0;
        e2 = rm[1] ? c : 0;
        e3 = rm[0] ? d : 0;
        e.s0 = e0;
        e.s1 = e0 + e1;
        e.s2 = e0 + e1 + e2;
        e.s3 = e0 + e1 + e2 + e3;
        m_tot = e.s3;
        m_ndraw = 0;
        if (m_tot == 0) begin
            e.nr = 1'b1;
            e.rn = 0;
        end else begin
            e.nr = 1'b0;
            m_ndraw = 1;
            while (m_lfsr > m_tot) begin
                m_lfsr = lfsr_next(m_lfsr);
                m_ndraw++;
            end
            e.rn   = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
        end
        sb.push_back(e);
    endtask

    // Issue one draw; latency is counted in clock edges from the start edge.
    task automatic draw(input int a, b, c, d, input logic [3:0] rm);
        int cyc;
        @(negedge clk);
        t0 = 4'(a); t1 = 4'(b); t2 = 4'(c); t3 = 4'(d);
        {r0, r1, r2, r3} = rm;
        predict(a, b, c, d, rm);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!enable && !done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                // Inputs after LOAD must not affect this draw.
                t0 = 4'($urandom); t1 = 4'($urandom); t2 = 4'($urandom); t3 = 4'($urandom);
                {r0, r1, r2, r3} = 4'($urandom);
            end
        end
        if (m_tot == 0) begin
            check("noreq_latency", cyc, 2);
            check("noreq_done", int'(done), 1);
        end else begin
            check("start_to_enable", cyc, 2 + m_ndraw);
            while (!done && cyc < 300) begin
                @(negedge clk);
                cyc++;
            end
            check("done_seen", int'(done), 1);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s0"}, int'(s0), 0);
        check({tag, "_s1"}, int'(s1), 0);
        check({tag, "_s2"}, int'(s2), 0);
        check({tag, "_s3"}, int'(s3), 0);
        check({tag, "_rn"}, int'(random_no), 0);
        check({tag, "_enable"}, int'(enable), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_no_req"}, int'(no_req), 0);
    endtask

    // Monitor: compares the DUT's outputs against the queued expectations.
    exp_t held;
    int   en_run = 0;
    bit   prev_en = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            en_run  = 0;
            prev_en = 1'b0;
        end else begin
            if (enable && !prev_en) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_underflow: enable rose with no expected draw at %0t", $time);
                end else begin
                    held = sb.pop_front();
                    check("grant_is_draw", int'(held.nr), 0);
                    check("s0", int'(s0), held.s0);
                    check("s1", int'(s1), held.s1);
                    check("s2", int'(s2), held.s2);
                    check("s3", int'(s3), held.s3);
                    check("random_no", int'(random_no), held.rn);
                    check("rn_in_range", int'(random_no >= 1 && random_no <= s3), 1);
                end
                en_run = 1;
            end else if (enable) begin
                check("s3_stable", int'(s3), held.s3);
                check("rn_stable", int'(random_no), held.rn);
                en_run++;
            end
            if (done) begin
                check("done_enable_low", int'(enable), 0);
                if (no_req) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL sb_underflow: no_req done with no expected draw at %0t", $time);
                    end else begin
                        held = sb.pop_front();
                        check("noreq_expected", int'(held.nr), 1);
                        check("noreq_s3", int'(s3), 0);
                    end
                end else begin
                    check("enable_hold_len", en_run, 1);
                end
                en_run = 0;
            end
            prev_en = enable;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int seq1[5] = '{1, 2, 4, 8, 16};
    int dcnt;

    initial begin
        rst = 1'b1; start = 1'b0;
        {r0, r1, r2, r3} = 4'b0;
        t0 = '0; t1 = '0; t2 = '0; t3 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_lfsr = 1;
        check_zero("reset");

        // Equal tickets: successive draws walk the LFSR sequence from seed 1.
        for (int i = 0; i < 5; i++) begin
            draw(4, 4, 4, 4, 4'b1111);
            check("seq_rn", int'(random_no), seq1[i]);
        end
        check("t1_s0", int'(s0), 4);
        check("t1_s1", int'(s1), 8);
        check("t1_s2", int'(s2), 12);
        check("t1_s3", int'(s3), 16);

        // Partial request mask.
        draw(5, 7, 3, 9, 4'b0101);
        check("mask_s0", int'(s0), 0);
        check("mask_s1", int'(s1), 7);
        check("mask_s2", int'(s2), 7);
        check("mask_s3", int'(s3), 16);

        // Zero total: no requests, then requests with zero tickets.
        draw(5, 7, 3, 9, 4'b0000);
        check("noreq_a_s3", int'(s3), 0);
        draw(0, 0, 0, 0, 4'b1111);
        check("noreq_b_s3", int'(s3), 0);

        // Single ticket: long rejection run until the LFSR returns to 1.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 1;
        draw(4, 4, 4, 4, 4'b1111);
        draw(4, 4, 4, 4, 4'b1111);
        draw(1, 0, 0, 0, 4'b1000);
        check("single_rn", int'(random_no), 1);

        // Reset in the middle of a long DRAW phase.
        @(negedge clk);
        t0 = 4'd1; t1 = '0; t2 = '0; t3 = '0;
        {r0, r1, r2, r3} = 4'b1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        check("mid_enable", int'(enable), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        dcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        m_lfsr = 1;
        draw(4, 4, 4, 4, 4'b1111);
        check("after_rst_rn", int'(random_no), 1);
        check("after_rst_s3", int'(s3), 16);

        // Random tickets and masks.
        for (int i = 0; i < 40; i++) begin
            draw(int'($urandom_range(15)), int'($urandom_range(15)),
                 int'($urandom_range(15)), int'($urandom_range(15)),
                 4'($urandom));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
